// File: rtl/xpb_pkg.sv
// Shared types and default sizes for the xpb lookup-table bank.
package xpb_pkg;

    localparam int unsigned XPB_DEF_NUM_LUTS  = 4;
    localparam int unsigned XPB_DEF_IDX_BITS  = 5;
    localparam int unsigned XPB_DEF_WORD_BITS = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } xpb_state_e;

    // Width of a select field for n items, never below one bit.
    function automatic int unsigned xpb_sel_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xpb_lut_ram.sv
// One lookup channel: single write port, registered read, entry 0 reads as zero.
module xpb_lut_ram #(
    parameter int unsigned IDX_BITS  = 5,
    parameter int unsigned WORD_BITS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  waddr,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [IDX_BITS-1:0]  raddr,
    output logic [WORD_BITS-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    logic [WORD_BITS-1:0] mem_q [DEPTH];
    logic [WORD_BITS-1:0] rdata_q;
    logic [WORD_BITS-1:0] rdata_d;

    // Storage is deliberately left unreset; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (raddr == '0) ? '0 : mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/xpb_lut_bank.sv
// Bank of NUM_LUTS independently loaded lookup tables read in lockstep.
// Optional XPB_ACCUM_EN adds a registered sum of all channel results.
module xpb_lut_bank
    import xpb_pkg::*;
#(
    parameter int unsigned NUM_LUTS  = XPB_DEF_NUM_LUTS,
    parameter int unsigned IDX_BITS  = XPB_DEF_IDX_BITS,
    parameter int unsigned WORD_BITS = XPB_DEF_WORD_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ld_valid,
    input  logic [xpb_sel_bits(NUM_LUTS)-1:0] ld_lut,
    input  logic [IDX_BITS-1:0]               ld_idx,
    input  logic [WORD_BITS-1:0]              ld_data,
    input  logic                              ld_last,
    output logic                              table_ready,
    input  logic                              lk_valid,
    input  logic [NUM_LUTS*IDX_BITS-1:0]      lk_idx,
    output logic                              out_valid,
    output logic [NUM_LUTS*WORD_BITS-1:0]     out_data,
    output logic                              lk_err
`ifdef XPB_ACCUM_EN
    ,
    output logic                                          acc_valid,
    output logic [WORD_BITS+xpb_sel_bits(NUM_LUTS)-1:0]   acc_data
`endif
);

    localparam int unsigned LUT_BITS = xpb_sel_bits(NUM_LUTS);

    xpb_state_e state_q, state_d;
    logic       ready_q, ready_d;
    logic       out_valid_q, out_valid_d;
    logic       lk_err_q, lk_err_d;
    logic       lk_accept_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            lk_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            lk_err_q    <= lk_err_d;
        end
    end

    // Any write leaves READY unless it closes the load; lookups only pass in READY.
    always_comb begin
        state_d     = state_q;
        lk_accept_c = 1'b0;
        lk_err_d    = lk_err_q;
        if (ld_valid) begin
            state_d = ld_last ? READY : LOADING;
        end
        if (lk_valid) begin
            if (state_q == READY) begin
                lk_accept_c = 1'b1;
            end else begin
                lk_err_d = 1'b1;
            end
        end
        out_valid_d = lk_accept_c;
        ready_d     = (state_d == READY);
    end

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        xpb_lut_ram #(
            .IDX_BITS  (IDX_BITS),
            .WORD_BITS (WORD_BITS)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (ld_valid && (ld_lut == LUT_BITS'(i))),
            .waddr (ld_idx),
            .wdata (ld_data),
            .re    (lk_accept_c),
            .raddr (lk_idx[i*IDX_BITS +: IDX_BITS]),
            .rdata (out_data[i*WORD_BITS +: WORD_BITS])
        );
    end

    assign table_ready = ready_q;
    assign out_valid   = out_valid_q;
    assign lk_err      = lk_err_q;

`ifdef XPB_ACCUM_EN
    localparam int unsigned ACC_W = WORD_BITS + LUT_BITS;

    logic             acc_valid_q, acc_valid_d;
    logic [ACC_W-1:0] acc_data_q, acc_data_d;
    logic [ACC_W-1:0] acc_sum_c;

    always_comb begin
        acc_sum_c = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            acc_sum_c = acc_sum_c + ACC_W'(out_data[i*WORD_BITS +: WORD_BITS]);
        end
        acc_valid_d = out_valid_q;
        acc_data_d  = out_valid_q ? acc_sum_c : acc_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
        end else begin
            acc_valid_q <= acc_valid_d;
            acc_data_q  <= acc_data_d;
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_data  = acc_data_q;
`endif

endmodule

// File: doc/xpb_lut_bank.md
XPB_LUT_BANK -- requirements
Module: xpb_lut_bank

Interface
REQ-001 SHALL have parameter NUM_LUTS, default 4, number of independent lookup channels.
REQ-002 SHALL have parameter IDX_BITS, default 5, index width; each table holds 2**IDX_BITS entries.
REQ-003 SHALL have parameter WORD_BITS, default 1024, width of each table entry.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ld_valid, input, 1, a table write is present this cycle.
REQ-007 SHALL have port ld_lut, input, clog2(NUM_LUTS), the target channel of the write.
REQ-008 SHALL have port ld_idx, input, IDX_BITS, the target entry of the write.
REQ-009 SHALL have port ld_data, input, WORD_BITS, the entry value to write.
REQ-010 SHALL have port ld_last, input, 1, marks the final write of a load sequence.
REQ-011 SHALL have port table_ready, output, 1, high when the tables are loaded and lookups are accepted.
REQ-012 SHALL have port lk_valid, input, 1, a lookup request is present this cycle.
REQ-013 SHALL have port lk_idx, input, NUM_LUTS*IDX_BITS, the packed per-channel indices, with channel 0 in the LSBs.
REQ-014 SHALL have port out_valid, output, 1, the lookup result is valid.
REQ-015 SHALL have port out_data, output, NUM_LUTS*WORD_BITS, the packed per-channel results, with channel 0 in the LSBs.
REQ-016 SHALL have port lk_err, output, 1, a sticky flag set when a lookup is dropped.

Function
REQ-017 SHALL implement an FSM with states IDLE, LOADING and READY; table_ready SHALL be 1 only in READY.
REQ-018 SHALL move from IDLE or READY to LOADING on ld_valid=1 with ld_last=0.
REQ-019 SHALL go to READY on ld_valid=1 with ld_last=1 in any state; that final write is committed.
REQ-020 SHALL write ld_data into table[ld_lut][ld_idx] on every cycle with ld_valid=1.
REQ-021 SHALL ignore writes with ld_idx=0 or ld_lut>=NUM_LUTS; entry 0 always reads as zero.
REQ-022 SHALL accept a lookup only when lk_valid=1 and the state is READY at that clock edge.
REQ-023 SHALL set out_valid and drive out_data exactly one cycle after an accepted lookup.
REQ-024 SHALL deassert out_valid in every cycle that does not follow an accepted lookup, while holding out_data at its last value.
REQ-025 SHALL sustain one lookup per cycle with no bubbles.
REQ-026 SHALL, when an accepted lookup and a write occur in the same cycle, return the pre-write contents for that lookup (read-before-write).
REQ-027 SHALL drop a lookup with lk_valid=1 outside READY (no out_valid) and set lk_err, which stays 1 until reset.

Reset
REQ-028 SHALL, on reset, force state=IDLE, table_ready=0, out_valid=0, out_data=0 and lk_err=0, with immediate effect.
REQ-029 SHALL NOT reset table storage; after reset a complete reload ending in ld_last is required before lookups are accepted.
REQ-030 SHALL, on reset mid-load or mid-lookup, discard the in-flight result and load progress.

Configuration
REQ-031 SHALL, when macro XPB_ACCUM_EN is defined, add output acc_valid (1 bit) and output acc_data (WORD_BITS+clog2(NUM_LUTS) bits).
REQ-032 SHALL, with XPB_ACCUM_EN, drive acc_data = unsigned sum of all NUM_LUTS out_data words, registered with acc_valid one cycle after out_valid (two cycles after lookup), and reset both to 0.
REQ-033 SHALL, without XPB_ACCUM_EN, omit acc_valid, acc_data and the adder logic entirely; all other behaviour is identical.

Structure
REQ-034 SHALL place the FSM state enum and the default parameter constants in the shared package xpb_pkg.
REQ-035 SHALL build each channel from one sub-module xpb_lut_ram: 2**IDX_BITS x WORD_BITS, one write port, synchronous read, entry 0 forced to zero.

Verification (NUM_LUTS=2, IDX_BITS=2, WORD_BITS=16)
REQ-036 SHALL cover: load ch0 idx1..3 = 0x0011/0x0022/0x0033 and ch1 idx1..3 = 0x0100/0x0200/0x0300 with ld_last on the final write, then lk_idx={ch1=2,ch0=3} -> one cycle later out_valid=1, out_data=0x0200_0033.
REQ-037 SHALL cover: lookups {0,0} then {1,1} back to back -> out_data 0x0000_0000 then 0x0100_0011 on consecutive cycles.
REQ-038 SHALL cover: after reset, lk_valid=1 with no load -> out_valid stays 0, lk_err=1 and it stays 1 until reset.
REQ-039 SHALL cover: in READY, write ch0 idx3=0xBEEF (ld_last=0) with a same-cycle lookup {0,3} -> result 0x0000_0033, table_ready drops next cycle, and after a later ld_last a lookup {0,3} returns 0x0000_BEEF.
REQ-040 SHALL cover: reset asserted mid-load -> table_ready=0 and out_valid=0 immediately, and lookups are dropped until a full reload.
REQ-041 SHALL cover, with XPB_ACCUM_EN: lookup {ch1=3,ch0=3} -> acc_valid=1 two cycles later with acc_data=0x00333.
